// File: rtl/fixed_point_pkg.sv
// Shared definitions for the sign-magnitude fixed-point datapath (Q4.11 at 16 bits).
// Holds word-size defaults, the MAC state encoding and the sign-magnitude to two's-complement helper.
package fixed_point_pkg;

   localparam int DEF_BITSIZE = 16;
   localparam int FRAC_BITS   = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Returns a 32-bit two's-complement value; callers slice it to their own width.
   // Negative zero maps to zero because the magnitude is tested before negation.
   function automatic logic signed [31:0] sm_to_tc(input logic [31:0] word, input int unsigned width);
      logic signed [31:0] mag;
      logic               sgn;
      sgn = word[width - 1];
      mag = signed'(word & ((32'd1 << (width - 1)) - 32'd1));
      if (sgn && (mag != 32'sd0)) begin
         return -mag;
      end
      return mag;
   endfunction

endpackage

// File: rtl/fixed_point_sat_pack.sv
// Clamps a wide two's-complement sum to +/-MAX and repacks it as sign-magnitude.
// The most negative word is unrepresentable in sign-magnitude and clamps to -MAX.
module fixed_point_sat_pack #(
   parameter int BITSIZE = 16,
   parameter int ACC_W   = 20
) (
   input  logic signed [ACC_W-1:0]   sum,
   output logic        [BITSIZE-1:0] data,
   output logic                      sat
);

   localparam logic signed [ACC_W-1:0] MAX_P = {{(ACC_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MAX_N = -MAX_P;

   logic signed [ACC_W-1:0] mag;

   // NOTE: every output gets a default first so no path through the if-chain can infer a latch.
   always_comb begin
      data = '0;
      sat  = 1'b0;
      mag  = (sum < 0) ? -sum : sum;
      if (sum > MAX_P) begin
         data = {1'b0, {(BITSIZE-1){1'b1}}};
         sat  = 1'b1;
      end else if (sum < MAX_N) begin
         data = {1'b1, {(BITSIZE-1){1'b1}}};
         sat  = 1'b1;
      end else begin
         data = {(sum < 0), mag[BITSIZE-2:0]};
      end
   end

endmodule

// File: rtl/fixed_point_mac_accumulator.sv
// Neuron dot-product stage: sums N_TERMS sign-magnitude products plus a bias,
// then saturates and presents the result on a valid/ready output.
module fixed_point_mac_accumulator
   import fixed_point_pkg::*;
#(
   parameter int BITSIZE = DEF_BITSIZE,
   parameter int N_TERMS = 8,
   parameter int GUARD   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BITSIZE-1:0] in_data,
   input  logic [BITSIZE-1:0] bias,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BITSIZE-1:0] out_data,
   output logic               out_sat,
   output logic               busy
);

   localparam int ACC_W = BITSIZE + GUARD;
   localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS + 1) : 1;

   // With N_TERMS <= 2^GUARD-1, (N_TERMS+1)*MAX cannot reach the accumulator sign bit.
   if (N_TERMS < 1 || N_TERMS > (2**GUARD) - 1) begin : g_bad_terms
      $error("fixed_point_mac_accumulator: N_TERMS out of range 1..2^GUARD-1");
   end
   if (ACC_W > 32) begin : g_bad_width
      $error("fixed_point_mac_accumulator: BITSIZE+GUARD must not exceed 32");
   end

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [31:0]      tc_in_full;
   logic signed [31:0]      tc_bias_full;
   logic signed [ACC_W-1:0] tc_in;
   logic signed [ACC_W-1:0] tc_bias;
   logic [CNT_W-1:0]        count;
   logic                    beat;
   logic                    last_beat;
   logic [BITSIZE-1:0]      sat_data;
   logic                    sat_flag;

   assign in_ready = (state != DONE);
   assign busy     = (state != IDLE);
   assign beat     = in_valid && in_ready;

   assign tc_in_full   = sm_to_tc(32'(in_data), BITSIZE);
   assign tc_bias_full = sm_to_tc(32'(bias), BITSIZE);
   assign tc_in        = tc_in_full[ACC_W-1:0];
   assign tc_bias      = tc_bias_full[ACC_W-1:0];

   always_comb begin
      acc_next = acc;
      case (state)
         IDLE:    acc_next = tc_bias + tc_in;
         ACCUM:   acc_next = acc + tc_in;
         default: acc_next = acc;
      endcase
   end

   assign last_beat = beat && (((state == IDLE) && (N_TERMS == 1)) ||
                               ((state == ACCUM) && (count == CNT_W'(N_TERMS - 1))));

   // The output register is fed from acc_next so the result lands on the final-beat edge.
   fixed_point_sat_pack #(
      .BITSIZE (BITSIZE),
      .ACC_W   (ACC_W)
   ) u_sat_pack (
      .sum  (acc_next),
      .data (sat_data),
      .sat  (sat_flag)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (beat) begin
                  acc   <= acc_next;
                  count <= CNT_W'(1);
                  state <= (N_TERMS == 1) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc   <= acc_next;
                  count <= count + 1'b1;
                  if (last_beat) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
                  acc   <= '0;
                  count <= '0;
               end
            end
            default: state <= IDLE;
         endcase

         if (last_beat) begin
            out_valid <= 1'b1;
            out_data  <= sat_data;
            out_sat   <= sat_flag;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
